// File: rtl/reg_wb_arbiter_if.sv
// Writeback bus between the two writeback sources and the register-file write port.
// The master side is the source pair; the slave side is the arbiter.
interface reg_wb_arbiter_if;
    logic        a_valid;
    logic [4:0]  a_id;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_id;
    logic [31:0] b_data;
    logic        b_ready;
    logic        enable_write;
    logic [4:0]  write_id;
    logic [31:0] write_data;
    logic        b_forced;

    modport master (
        output a_valid, a_id, a_data, b_valid, b_id, b_data,
        input  a_ready, b_ready, enable_write, write_id, write_data, b_forced
    );

    modport slave (
        input  a_valid, a_id, a_data, b_valid, b_id, b_data,
        output a_ready, b_ready, enable_write, write_id, write_data, b_forced
    );
endinterface

// File: rtl/reg_wb_arbiter.sv
// Two-source arbiter for the register file's single write port: source A has fixed
// priority, source B is force-granted after MAX_WAIT consecutive refusals.
module reg_wb_arbiter #(
    parameter int MAX_WAIT = 3,
    parameter int WAIT_W   = 2
) (
    input  logic          clk,
    input  logic          reset,
    reg_wb_arbiter_if.slave bus
);

    localparam logic [WAIT_W-1:0] WAIT_SAT_C = {WAIT_W{1'b1}};
    localparam logic [WAIT_W-1:0] WAIT_ONE_C = WAIT_W'(1);

    logic [WAIT_W-1:0] wait_cnt_r;
    logic              force_b_s;
    logic              grant_a_s;
    logic              grant_b_s;

    logic              enable_write_r;
    logic [4:0]        write_id_r;
    logic [31:0]       write_data_r;
    logic              b_forced_r;

    // Grant decision; nothing is accepted while reset is held.
    always_comb begin
        force_b_s = 1'b0;
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (reset) begin
            force_b_s = 1'b0;
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end else begin
            force_b_s = (int'(wait_cnt_r) >= MAX_WAIT);
            grant_b_s = bus.b_valid && (!bus.a_valid || force_b_s);
            grant_a_s = bus.a_valid && !grant_b_s;
        end
    end

    assign bus.a_ready = grant_a_s;
    assign bus.b_ready = grant_b_s;

    // Starvation counter: counts consecutive cycles B waited, saturating.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else if (bus.b_valid && !grant_b_s) begin
            if (wait_cnt_r != WAIT_SAT_C) begin
                wait_cnt_r <= wait_cnt_r + WAIT_ONE_C;
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
        end else begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end
    end

    // Write-port register; id/data hold when idle, and $zero writes never enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            enable_write_r <= 1'b0;
            write_id_r     <= 5'd0;
            write_data_r   <= 32'd0;
            b_forced_r     <= 1'b0;
        end else if (grant_a_s) begin
            enable_write_r <= (bus.a_id != 5'd0);
            write_id_r     <= bus.a_id;
            write_data_r   <= bus.a_data;
            b_forced_r     <= 1'b0;
        end else if (grant_b_s) begin
            enable_write_r <= (bus.b_id != 5'd0);
            write_id_r     <= bus.b_id;
            write_data_r   <= bus.b_data;
            b_forced_r     <= bus.a_valid;
        end else begin
            enable_write_r <= 1'b0;
            write_id_r     <= write_id_r;
            write_data_r   <= write_data_r;
            b_forced_r     <= 1'b0;
        end
    end

    assign bus.enable_write = enable_write_r;
    assign bus.write_id     = write_id_r;
    assign bus.write_data   = write_data_r;
    assign bus.b_forced     = b_forced_r;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed-vector bench for reg_wb_arbiter: readies checked in-cycle, registered
// write-port outputs checked by a monitor draining a scoreboard queue.
module tb_reg_wb_arbiter;

    logic clk;
    logic reset;

    reg_wb_arbiter_if bus3 ();
    reg_wb_arbiter_if bus0 ();

    reg_wb_arbiter #(.MAX_WAIT(3), .WAIT_W(2)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3.slave)
    );

    reg_wb_arbiter #(.MAX_WAIT(0), .WAIT_W(2)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    typedef struct {
        bit          inst;
        logic        en;
        logic [4:0]  id;
        logic [31:0] data;
        logic        bf;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: one registered output expectation per cycle, popped after each edge.
    initial begin
        exp_t        e;
        logic        a_en;
        logic [4:0]  a_id;
        logic [31:0] a_data;
        logic        a_bf;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.inst) begin
                    a_en = bus0.enable_write; a_id = bus0.write_id;
                    a_data = bus0.write_data; a_bf = bus0.b_forced;
                end else begin
                    a_en = bus3.enable_write; a_id = bus3.write_id;
                    a_data = bus3.write_data; a_bf = bus3.b_forced;
                end
                n_cmp++;
                if (a_en !== e.en || a_id !== e.id || a_data !== e.data || a_bf !== e.bf) begin
                    n_fail++;
                    $display("FAIL wb_out inst%0d: got en=%0b id=%0d data=%h bf=%0b, want en=%0b id=%0d data=%h bf=%0b",
                             e.inst, a_en, a_id, a_data, a_bf, e.en, e.id, e.data, e.bf);
                end
            end
        end
    end

    task automatic vec(input bit inst, input logic rst,
                       input logic av, input logic [4:0] aid, input logic [31:0] ad,
                       input logic bv, input logic [4:0] bid, input logic [31:0] bd,
                       input logic ar, input logic br,
                       input logic en, input logic [4:0] id, input logic [31:0] d, input logic bf);
        exp_t e;
        logic got_ar;
        logic got_br;
        @(negedge clk);
        reset = rst;
        bus3.a_valid = 1'b0; bus3.a_id = 5'd0; bus3.a_data = 32'd0;
        bus3.b_valid = 1'b0; bus3.b_id = 5'd0; bus3.b_data = 32'd0;
        bus0.a_valid = 1'b0; bus0.a_id = 5'd0; bus0.a_data = 32'd0;
        bus0.b_valid = 1'b0; bus0.b_id = 5'd0; bus0.b_data = 32'd0;
        if (inst) begin
            bus0.a_valid = av; bus0.a_id = aid; bus0.a_data = ad;
            bus0.b_valid = bv; bus0.b_id = bid; bus0.b_data = bd;
        end else begin
            bus3.a_valid = av; bus3.a_id = aid; bus3.a_data = ad;
            bus3.b_valid = bv; bus3.b_id = bid; bus3.b_data = bd;
        end
        #1;
        got_ar = inst ? bus0.a_ready : bus3.a_ready;
        got_br = inst ? bus0.b_ready : bus3.b_ready;
        n_cmp++;
        if (got_ar !== ar || got_br !== br) begin
            n_fail++;
            $display("FAIL ready inst%0d: got a_ready=%0b b_ready=%0b, want a_ready=%0b b_ready=%0b",
                     inst, got_ar, got_br, ar, br);
        end
        e.inst = inst; e.en = en; e.id = id; e.data = d; e.bf = bf;
        sb.push_back(e);
    endtask

    initial begin
        int guard;
        reset = 1'b1;
        bus3.a_valid = 1'b0; bus3.a_id = 5'd0; bus3.a_data = 32'd0;
        bus3.b_valid = 1'b0; bus3.b_id = 5'd0; bus3.b_data = 32'd0;
        bus0.a_valid = 1'b0; bus0.a_id = 5'd0; bus0.a_data = 32'd0;
        bus0.b_valid = 1'b0; bus0.b_id = 5'd0; bus0.b_data = 32'd0;

        //   inst  rst   av    aid    adata          bv    bid    bdata          ar    br    en    id     data           bf
        vec(1'b0, 1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         1'b0);
        vec(1'b0, 1'b1, 1'b1, 5'd7,  32'h1,         1'b1, 5'd8,  32'h2,         1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         1'b0);
        vec(1'b0, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF,  1'b0, 5'd0,  32'h0,         1'b1, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF,  1'b0);
        vec(1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 1'b0, 5'd5,  32'hDEADBEEF,  1'b0);
        // both valid once, A drops after its accept
        vec(1'b0, 1'b0, 1'b1, 5'd3,  32'h11,        1'b1, 5'd4,  32'h22,        1'b1, 1'b0, 1'b1, 5'd3,  32'h11,        1'b0);
        vec(1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 5'd4,  32'h22,        1'b0, 1'b1, 1'b1, 5'd4,  32'h22,        1'b0);
        vec(1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 1'b0, 5'd4,  32'h22,        1'b0);
        // sustained contention: B forced on cycles 3 and 7, A holds its request meanwhile
        vec(1'b0, 1'b0, 1'b1, 5'd1,  32'hA0,        1'b1, 5'd9,  32'h99,        1'b1, 1'b0, 1'b1, 5'd1,  32'hA0,        1'b0);
        vec(1'b0, 1'b0, 1'b1, 5'd2,  32'hA1,        1'b1, 5'd9,  32'h99,        1'b1, 1'b0, 1'b1, 5'd2,  32'hA1,        1'b0);
        vec(1'b0, 1'b0, 1'b1, 5'd3,  32'hA2,        1'b1, 5'd9,  32'h99,        1'b1, 1'b0, 1'b1, 5'd3,  32'hA2,        1'b0);
        vec(1'b0, 1'b0, 1'b1, 5'd4,  32'hA3,        1'b1, 5'd9,  32'h99,        1'b0, 1'b1, 1'b1, 5'd9,  32'h99,        1'b1);
        vec(1'b0, 1'b0, 1'b1, 5'd4,  32'hA3,        1'b1, 5'd9,  32'h99,        1'b1, 1'b0, 1'b1, 5'd4,  32'hA3,        1'b0);
        vec(1'b0, 1'b0, 1'b1, 5'd5,  32'hA4,        1'b1, 5'd9,  32'h99,        1'b1, 1'b0, 1'b1, 5'd5,  32'hA4,        1'b0);
        vec(1'b0, 1'b0, 1'b1, 5'd6,  32'hA5,        1'b1, 5'd9,  32'h99,        1'b1, 1'b0, 1'b1, 5'd6,  32'hA5,        1'b0);
        vec(1'b0, 1'b0, 1'b1, 5'd7,  32'hA6,        1'b1, 5'd9,  32'h99,        1'b0, 1'b1, 1'b1, 5'd9,  32'h99,        1'b1);
        vec(1'b0, 1'b0, 1'b1, 5'd7,  32'hA6,        1'b1, 5'd9,  32'h99,        1'b1, 1'b0, 1'b1, 5'd7,  32'hA6,        1'b0);
        vec(1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 1'b0, 5'd7,  32'hA6,        1'b0);
        // $zero writes from each source: accepted, never enabled
        vec(1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  32'h55,        1'b0, 1'b1, 1'b0, 5'd0,  32'h55,        1'b0);
        vec(1'b0, 1'b0, 1'b1, 5'd0,  32'h77,        1'b0, 5'd0,  32'h0,         1'b1, 1'b0, 1'b0, 5'd0,  32'h77,        1'b0);
        // reset mid-stream with B already waiting twice; counter must restart from 0
        vec(1'b0, 1'b0, 1'b1, 5'd12, 32'h1234,      1'b1, 5'd13, 32'h5678,      1'b1, 1'b0, 1'b1, 5'd12, 32'h1234,      1'b0);
        vec(1'b0, 1'b0, 1'b1, 5'd14, 32'hAAAA,      1'b1, 5'd13, 32'h5678,      1'b1, 1'b0, 1'b1, 5'd14, 32'hAAAA,      1'b0);
        vec(1'b0, 1'b1, 1'b1, 5'd14, 32'hAAAA,      1'b1, 5'd13, 32'h5678,      1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         1'b0);
        vec(1'b0, 1'b0, 1'b1, 5'd15, 32'hF,         1'b1, 5'd13, 32'h5678,      1'b1, 1'b0, 1'b1, 5'd15, 32'hF,         1'b0);
        vec(1'b0, 1'b0, 1'b1, 5'd16, 32'h10,        1'b1, 5'd13, 32'h5678,      1'b1, 1'b0, 1'b1, 5'd16, 32'h10,        1'b0);
        vec(1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 1'b0, 5'd16, 32'h10,        1'b0);
        // MAX_WAIT=0 instance: B always wins when valid
        vec(1'b1, 1'b0, 1'b1, 5'd1,  32'h100,       1'b1, 5'd2,  32'h200,       1'b0, 1'b1, 1'b1, 5'd2,  32'h200,       1'b1);
        vec(1'b1, 1'b0, 1'b1, 5'd1,  32'h100,       1'b1, 5'd3,  32'h300,       1'b0, 1'b1, 1'b1, 5'd3,  32'h300,       1'b1);
        vec(1'b1, 1'b0, 1'b1, 5'd1,  32'h100,       1'b1, 5'd4,  32'h400,       1'b0, 1'b1, 1'b1, 5'd4,  32'h400,       1'b1);
        vec(1'b1, 1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 5'd5,  32'h500,       1'b0, 1'b1, 1'b1, 5'd5,  32'h500,       1'b0);
        vec(1'b1, 1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 1'b0, 5'd5,  32'h500,       1'b0);

        guard = 0;
        while (sb.size() != 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
